// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions for the transmitter and receiver:
//   parity_e       - line parity mode (NONE / ODD / EVEN)
//   tx_state_e     - transmitter frame-sequencing states
//   bit_period()   - elaboration-time clocks-per-bit, rounded to nearest
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_HOLD
    } tx_state_e;

    // Clocks per line bit, rounded to the nearest integer.
    function automatic int bit_period(input int clk_frequency, input int baud_rate);
        return (clk_frequency + baud_rate / 2) / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Loadable down-counter that marks the last clock of every line bit.
// Ports:
//   clk     in   system clock
//   rst     in   asynchronous active-high reset
//   clear   in   synchronous restart; the following BIT_PERIOD cycles form
//                one full bit
//   bit_end out  high on the final cycle of each BIT_PERIOD-long bit
// -----------------------------------------------------------------------------
module uart_baud_gen #(
    parameter int BIT_PERIOD = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);

    localparam int            CW     = $clog2(BIT_PERIOD);
    localparam logic [CW-1:0] RELOAD = CW'(BIT_PERIOD - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= RELOAD;
        end else if (clear || cnt == '0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - CW'(1);
        end
    end

    assign bit_end = (cnt == '0);

endmodule

// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
// Sends one UART frame (start, 8 data bits LSB first, optional parity,
// 1 or 2 stop bits) per accepted Send request.
// Ports:
//   ipClk     in   system clock
//   ipReset   in   asynchronous active-high reset (aborts any frame)
//   ipTxData  in   byte to send, sampled only on the accept cycle
//   ipTxSend  in   level-sensitive send request, accepted while idle
//   opTxBusy  out  high from the cycle after accept until the frame has
//                  finished and ipTxSend is low
//   opTx      out  registered serial line, idles high
// -----------------------------------------------------------------------------
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLK_FREQUENCY = 50_000_000,
    parameter int BAUD_RATE     = 115_200,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1
) (
    input  logic       ipClk,
    input  logic       ipReset,
    input  logic [7:0] ipTxData,
    input  logic       ipTxSend,
    output logic       opTxBusy,
    output logic       opTx
);

    localparam int      BIT_PERIOD = bit_period(CLK_FREQUENCY, BAUD_RATE);
    localparam parity_e PAR_MODE   = parity_e'(PARITY[1:0]);
    localparam logic    STOP_LAST  = (STOP_BITS == 2);

    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_transmitter: STOP_BITS must be 1 or 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_transmitter: PARITY must be 0, 1 or 2");
    end
    if (BIT_PERIOD < 2) begin : g_bad_period
        $error("uart_transmitter: bit period must be at least 2 clocks");
    end

    // Even parity is the XOR of the data; odd parity is its complement.
    function automatic logic parity_bit(input logic [7:0] d);
        return (PAR_MODE == PAR_ODD) ? ~^d : ^d;
    endfunction

    tx_state_e  state, state_next;
    logic [2:0] bit_idx, bit_idx_next;
    logic       stop_cnt, stop_cnt_next;
    logic [7:0] shreg, shreg_next;
    logic       par_reg, par_next;
    logic       tx_next;
    logic       busy_next;
    logic       baud_clear;
    logic       bit_end;

    uart_baud_gen #(
        .BIT_PERIOD (BIT_PERIOD)
    ) u_baud_gen (
        .clk     (ipClk),
        .rst     (ipReset),
        .clear   (baud_clear),
        .bit_end (bit_end)
    );

    always_comb begin
        state_next    = state;
        bit_idx_next  = bit_idx;
        stop_cnt_next = stop_cnt;
        shreg_next    = shreg;
        par_next      = par_reg;
        baud_clear    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (ipTxSend) begin
                    state_next    = ST_START;
                    shreg_next    = ipTxData;
                    par_next      = parity_bit(ipTxData);
                    bit_idx_next  = 3'd0;
                    stop_cnt_next = 1'b0;
                    // Bit timing is phase-locked to the accept edge.
                    baud_clear    = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) state_next = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        state_next = (PAR_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                        shreg_next   = {1'b0, shreg[7:1]};
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) state_next = ST_STOP;
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (stop_cnt == STOP_LAST) begin
                        // A request still asserted here is the one just served.
                        state_next = ipTxSend ? ST_HOLD : ST_IDLE;
                    end else begin
                        stop_cnt_next = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (!ipTxSend) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        // Line level is decoded from the next state so opTx is a clean flop.
        case (state_next)
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = shreg_next[0];
            ST_PARITY: tx_next = par_next;
            default:   tx_next = 1'b1;
        endcase

        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge ipClk or posedge ipReset) begin
        if (ipReset) begin
            state    <= ST_IDLE;
            bit_idx  <= 3'd0;
            stop_cnt <= 1'b0;
            opTx     <= 1'b1;
            opTxBusy <= 1'b0;
        end else begin
            state    <= state_next;
            bit_idx  <= bit_idx_next;
            stop_cnt <= stop_cnt_next;
            opTx     <= tx_next;
            opTxBusy <= busy_next;
        end
    end

    // Payload registers carry no reset; they are reloaded on every accept.
    always_ff @(posedge ipClk) begin
        shreg   <= shreg_next;
        par_reg <= par_next;
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// -----------------------------------------------------------------------------
// tb_uart_transmitter
// Three transmitter configurations run side by side: defaults (434 clk/bit,
// no parity, 1 stop), even parity with 2 stop bits, and odd parity with a
// rounded bit period. Each has a stimulus process pushing expected frames
// into a queue and a monitor that rebuilds the expected line waveform and
// decodes the received byte.
// -----------------------------------------------------------------------------
module tb_uart_transmitter;

    typedef struct {
        logic [7:0] data;
        bit         held;
        bit         b2b;
    } item_t;

    typedef logic bitq_t[$];

    localparam int NCFG = 3;
    localparam int CFA [NCFG] = '{50_000_000, 1_000_000, 1_000_000};
    localparam int BRA [NCFG] = '{115_200,    100_000,   90_000};
    localparam int PRA [NCFG] = '{0, 2, 1};
    localparam int SBA [NCFG] = '{1, 2, 1};
    localparam int HLA [NCFG] = '{10000, 300, 300};
    localparam int RCA [NCFG] = '{2000, 50, 50};
    localparam int NRA [NCFG] = '{2, 24, 24};
    localparam logic [7:0] D0A [NCFG] = '{8'h55, 8'h07, 8'h07};
    localparam logic [7:0] D1A [NCFG] = '{8'hFF, 8'hFF, 8'h80};

    int   checks = 0;
    int   errors = 0;
    logic clk = 1'b0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected line levels of one frame, one entry per bit.
    function automatic bitq_t frame_bits(input logic [7:0] d, input int par, input int sb);
        bitq_t b;
        int    ones;
        b.push_back(1'b0);
        for (int i = 0; i < 8; i++) b.push_back(d[i]);
        ones = $countones(d);
        if (par == 1) b.push_back((ones % 2 == 0) ? 1'b1 : 1'b0);
        if (par == 2) b.push_back((ones % 2 == 1) ? 1'b1 : 1'b0);
        for (int i = 0; i < sb; i++) b.push_back(1'b1);
        return b;
    endfunction

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int CF = CFA[g];
        localparam int BR = BRA[g];
        localparam int PR = PRA[g];
        localparam int SB = SBA[g];
        localparam int P  = $rtoi(real'(CF) / real'(BR) + 0.5);
        localparam int WAIT_MAX = 40 * P;

        logic       rst   = 1'b0;
        logic       send  = 1'b0;
        logic [7:0] data  = 8'h00;
        logic       busy;
        logic       tx;
        bit         abort = 1'b1;
        bit         done  = 1'b0;

        item_t q[$];
        int    pos       = -1;
        int    len       = 0;
        int    cyc       = 0;
        int    last_fall = -100;
        int    mism      = 0;
        item_t cur;
        bitq_t expb;
        logic [7:0] rx;

        uart_transmitter #(
            .CLK_FREQUENCY (CF),
            .BAUD_RATE     (BR),
            .PARITY        (PR),
            .STOP_BITS     (SB)
        ) dut (
            .ipClk    (clk),
            .ipReset  (rst),
            .ipTxData (data),
            .ipTxSend (send),
            .opTxBusy (busy),
            .opTx     (tx)
        );

        // Monitor: matches the line against the oldest accepted request.
        always @(negedge clk) begin
            cyc++;
            if (abort) begin
                pos = -1;
            end else if (pos < 0 && tx === 1'b0) begin
                if (q.size() == 0) begin
                    chk($sformatf("c%0d unexpected_start_tx", g), tx, 1);
                end else begin
                    cur  = q.pop_front();
                    expb = frame_bits(cur.data, PR, SB);
                    len  = expb.size() * P;
                    pos  = 0;
                    mism = 0;
                    if (cur.b2b)
                        chk($sformatf("c%0d b2b_gap_le2", g), 32'(cyc - last_fall <= 2), 1);
                end
            end
            if (!abort && pos >= 0) begin
                if (pos == len) begin
                    chk($sformatf("c%0d line_after_frame", g), tx, 1);
                    chk($sformatf("c%0d busy_after_frame", g), busy, cur.held);
                    chk($sformatf("c%0d rx_byte", g), rx, cur.data);
                    last_fall = cyc;
                    pos = -1;
                end else begin
                    if (tx !== expb[pos / P] || busy !== 1'b1) mism++;
                    if (pos % P == P / 2 && pos / P >= 1 && pos / P <= 8)
                        rx[pos / P - 1] = tx;
                    if (pos % P == P - 1) begin
                        chk($sformatf("c%0d data%02h bit%0d bad_cycles", g, cur.data, pos / P),
                            mism, 0);
                        mism = 0;
                    end
                    pos++;
                end
            end
        end

        task automatic send_frame(input logic [7:0] d, input int hold, input bit b2b,
                                  input int gap);
            int k;
            k = 0;
            while (busy !== 1'b0 && k < WAIT_MAX) begin
                @(negedge clk);
                k++;
            end
            chk($sformatf("c%0d wait_idle_busy", g), busy, 0);
            repeat (gap) @(negedge clk);
            data = d;
            send = 1'b1;
            q.push_back('{data: d, held: (hold > 0), b2b: b2b});
            @(negedge clk);
            chk($sformatf("c%0d busy_rise", g), busy, 1);
            if (hold == 0) begin
                data = ~d;
                send = 1'b0;
            end else begin
                data = 8'h00;
                repeat (hold - 1) @(negedge clk);
                chk($sformatf("c%0d hold_busy", g), busy, 1);
                send = 1'b0;
                @(negedge clk);
                chk($sformatf("c%0d hold_release_busy", g), busy, 0);
            end
        endtask

        initial begin
            logic [7:0] d;
            bit         bb;
            int         k;
            int         bad;

            #1 rst = 1'b1;
            #1;
            chk($sformatf("c%0d reset_tx", g), tx, 1);
            chk($sformatf("c%0d reset_busy", g), busy, 0);
            repeat (3) @(negedge clk);
            #1 rst = 1'b0;
            @(posedge clk);
            abort = 1'b0;

            send_frame(D0A[g], 0, 1'b0, 2);
            send_frame(D1A[g], 0, 1'b0, 3);
            send_frame(8'hA5, HLA[g], 1'b0, 1);
            send_frame(8'h41, 0, 1'b0, 1);
            send_frame(8'h0A, 0, 1'b1, 0);
            for (int i = 0; i < NRA[g]; i++) begin
                d  = 8'($urandom);
                bb = 1'($urandom_range(0, 1));
                send_frame(d, 0, bb, bb ? 0 : int'($urandom_range(1, 5)));
            end

            // Abort a frame part-way through with an asynchronous reset.
            send_frame(8'($urandom), 0, 1'b0, 1);
            repeat (RCA[g]) @(negedge clk);
            #1;
            abort = 1'b1;
            rst   = 1'b1;
            #1;
            chk($sformatf("c%0d abort_tx", g), tx, 1);
            chk($sformatf("c%0d abort_busy", g), busy, 0);
            q.delete();
            repeat (3) @(negedge clk);
            #1 rst = 1'b0;
            bad = 0;
            repeat (200) begin
                @(negedge clk);
                if (tx !== 1'b1 || busy !== 1'b0) bad++;
            end
            chk($sformatf("c%0d idle_after_abort_bad_cycles", g), bad, 0);
            #1 abort = 1'b0;
            send_frame(8'($urandom), 0, 1'b0, 2);

            k = 0;
            while ((q.size() != 0 || pos >= 0) && k < WAIT_MAX) begin
                @(negedge clk);
                k++;
            end
            chk($sformatf("c%0d drain_pending", g), 32'(q.size()) + 32'(pos >= 0), 0);
            done = 1'b1;
        end
    end

    initial begin
        int k;
        k = 0;
        while (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done) && k < 98000) begin
            @(negedge clk);
            k++;
        end
        chk("all_configs_done",
            {29'd0, g_cfg[2].done, g_cfg[1].done, g_cfg[0].done}, 32'd7);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
Serial transmitter that responds to the TxData/TxSend/TxBusy handshake and drives the UART line, one frame per accepted byte. Sits under the UART wrapper beside the receiver. The top-level echo logic is its only client: it raises Send while Busy is low and drops Send once it sees Busy. Frame format (parity, stop bits) and baud rate are set at elaboration.

Parameters:
CLK_FREQUENCY, 50_000_000, ipClk frequency in Hz
BAUD_RATE, 115_200, line rate in bits per second
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2; any other value is an elaboration error

Ports:
ipClk  input  1  system clock; all logic on its rising edge
ipReset  input  1  asynchronous, active-high reset
ipTxData  input  8  byte to send; sampled only on the accept cycle
ipTxSend  input  1  send request, level-sensitive
opTxBusy  output  1  high from the cycle after accept until the frame is done and ipTxSend is low
opTx  output  1  serial line, idles high, registered (glitch-free)

Behaviour:
- Reset (async assert, sync release): opTx=1, opTxBusy=0, state IDLE, bit counters cleared. Asserting reset mid-frame aborts the frame and opTx returns high at once; no partial frame resumes.
- BIT_PERIOD = round(CLK_FREQUENCY/BAUD_RATE), computed at elaboration, must be >= 2. Defaults give 434.
- Every line bit lasts exactly BIT_PERIOD cycles. The baud counter restarts at the accept cycle, so there is no phase jitter against a free-running tick.
- Accept: in IDLE, if ipTxSend=1 on edge n, latch ipTxData into the shift register. On edge n+1, opTxBusy=1 and opTx=0 (start bit), i.e. one-cycle latency.
- ipTxSend while opTxBusy=1 is ignored. ipTxData changes after accept have no effect.
- States and transitions:
  IDLE -> START on accept.
  START -> DATA after BIT_PERIOD.
  DATA sends 8 bits, LSB first. After bit 7 it goes to PARITY if PARITY!=0, else to STOP.
  PARITY sends one bit so the total count of ones across data and parity is odd (PARITY=1) or even (PARITY=2), then goes to STOP.
  STOP holds opTx=1 for STOP_BITS*BIT_PERIOD, then goes to IDLE if ipTxSend=0, else to HOLD.
  HOLD keeps opTx=1 and opTxBusy=1 until ipTxSend=0, then goes to IDLE. This guarantees one frame per request.
- opTxBusy falls on the edge the state enters IDLE. A new request seen in IDLE is accepted on the next edge, so back-to-back frames have no idle gap beyond one clock.
- Frame length in cycles: (1 + 8 + (PARITY!=0) + STOP_BITS) * BIT_PERIOD. Defaults give 4340.
- Counter widths: baud counter $clog2(BIT_PERIOD); data bit index 3 bits; stop counter 1 bit. No wrap inside a frame.

Decomposition:
- Package uart_pkg holds:
  - the parity enum (NONE/ODD/EVEN);
  - the tx state typedef (IDLE/START/DATA/PARITY/STOP/HOLD);
  - the constant function computing BIT_PERIOD from the two parameters.
  The receiver shares the parity enum and bit-period function.
- One sub-module, uart_baud_gen: a loadable down-counter producing a one-cycle bit_end strobe every BIT_PERIOD cycles, restarted by a sync clear. The FSM, shift register and parity generator stay in uart_transmitter.

Test Plan:
- Defaults, ipTxData=0x55 with a one-shot Send (dropped on Busy) -> opTx low for 434 cycles, then 1,0,1,0,1,0,1,0 at 434 cycles each, then high. opTxBusy high for exactly 4340 cycles starting one cycle after accept.
- PARITY=2, ipTxData=0x07 -> parity bit 1. PARITY=1, same data -> parity bit 0. Frame 4774 cycles.
- STOP_BITS=2, ipTxData=0xFF -> start low 434 cycles, then line high for 8*434 + 868 cycles. Busy length 4774.
- Send held high 10000 cycles -> exactly one frame, Busy stays high in HOLD, and Busy falls the cycle after Send drops. Changing ipTxData to 0x00 mid-frame leaves the transmitted bits unchanged.
- Echo-style client sending 0x41 then 0x0A back-to-back -> second start bit begins within 2 cycles of the first frame's Busy fall; both bytes decode correctly in a reference receiver model.
- Reset pulsed at cycle 2000 of a frame -> opTx=1 and opTxBusy=0 in the same cycle (async). After release and no Send, the line stays idle high; a new Send afterwards yields a clean full frame.
